// File: rtl/sm83_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sm83_irq_pkg
// Description : Shared constants and types for the SM83 interrupt controller.
//               Source bit indices follow the IF/IE register layout.
//               Default bus addresses are given for IF (0xFF0F) and IE (0xFFFF).
// Revision    : 1.0 - initial release
// ============================================================================
package sm83_irq_pkg;

    // Source bit positions in IF / IE
    localparam int IRQ_VBLANK = 0;
    localparam int IRQ_STAT   = 1;
    localparam int IRQ_TIMER  = 2;
    localparam int IRQ_SERIAL = 3;
    localparam int IRQ_JOYPAD = 4;

    // Default register addresses on the CPU external bus
    localparam logic [15:0] IF_ADR_DEFAULT = 16'hff0f;
    localparam logic [15:0] IE_ADR_DEFAULT = 16'hffff;

    // One byte-wide interrupt vector (IE register, core irq/iack word)
    typedef logic [7:0] irq_t;

endpackage : sm83_irq_pkg
`default_nettype wire

// File: rtl/sm83_irq_edge.sv
`default_nettype none
// ============================================================================
// Module      : sm83_irq_edge
// Description : One peripheral request line: SYNC_STAGES-deep synchronizer
//               followed by a rising-edge detector.
//               SYNC_STAGES = 0 means the line is already synchronous to clk.
// Ports       : clk      - system clock
//               n_reset  - asynchronous active-low reset
//               src      - raw request level
//               src_edge - one-cycle pulse on a synchronized rising edge
// Revision    : 1.0 - initial release
// ============================================================================
module sm83_irq_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic n_reset,
    input  logic src,
    output logic src_edge
);

    logic w_sync;
    logic r_prev;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign w_sync = src;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;

            always_ff @(posedge clk or negedge n_reset) begin
                if (!n_reset) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= src;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_sync = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_sync;
        end
    end

    // Prev resets to 0, so a line held high through reset yields one edge.
    assign src_edge = w_sync & ~r_prev;

endmodule : sm83_irq_edge
`default_nettype wire

// File: rtl/sm83_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sm83_irq_ctrl
// Description : SM83 interrupt controller. Captures peripheral rising edges
//               into IF, masks with IE, presents IF & IE to the core and
//               clears IF bits on acknowledge. IF/IE are bus mapped.
// Ports       : clk, n_reset      - clock, async active-low reset
//               src[NUM_SRC]      - peripheral request lines
//               adr, wdata, rd, wr- CPU external bus
//               rdata, sel        - read data and read-hit select
//               irq[NUM_IRQS]     - pending interrupts to the core
//               iack[NUM_IRQS]    - acknowledge from the core
//               wake              - any interrupt pending (HALT/STOP exit)
// Revision    : 1.0 - initial release
// ============================================================================
module sm83_irq_ctrl
    import sm83_irq_pkg::*;
#(
    parameter int          NUM_IRQS    = 8,
    parameter int          NUM_SRC     = 5,
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] IF_ADR      = IF_ADR_DEFAULT,
    parameter logic [15:0] IE_ADR      = IE_ADR_DEFAULT
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic [NUM_SRC-1:0]  src,
    input  logic [15:0]         adr,
    input  logic [7:0]          wdata,
    output logic [7:0]          rdata,
    input  logic                rd,
    input  logic                wr,
    output logic                sel,
    output logic [NUM_IRQS-1:0] irq,
    input  logic [NUM_IRQS-1:0] iack,
    output logic                wake
);

    logic [NUM_SRC-1:0] w_src_edge;
    logic [NUM_SRC-1:0] r_if;
    logic [NUM_SRC-1:0] w_if_next;
    irq_t               r_ie;
    logic               r_wr_d;
    logic               w_wr_pulse;
    logic               w_hit_if;
    logic               w_hit_ie;

    // Upper iack/wdata bits have no backing IF storage.
    logic w_unused;
    assign w_unused = ^{iack, wdata};

    generate
        for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
            sm83_irq_edge #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_edge (
                .clk      (clk),
                .n_reset  (n_reset),
                .src      (src[g]),
                .src_edge (w_src_edge[g])
            );
        end
    endgenerate

    assign w_hit_if   = (adr == IF_ADR);
    assign w_hit_ie   = (adr == IE_ADR);
    // A held wr only writes on its first cycle.
    assign w_wr_pulse = wr & ~r_wr_d;

    // Per-bit priority: peripheral edge, then ack, then CPU write, then hold.
    // Giving the edge top priority keeps a new request from being lost.
    always_comb begin
        w_if_next = r_if;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_src_edge[i]) begin
                w_if_next[i] = 1'b1;
            end else if (iack[i]) begin
                w_if_next[i] = 1'b0;
            end else if (w_wr_pulse && w_hit_if) begin
                w_if_next[i] = wdata[i];
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_if   <= '0;
            r_ie   <= '0;
            r_wr_d <= 1'b0;
        end else begin
            r_if   <= w_if_next;
            r_wr_d <= wr;
            if (w_wr_pulse && w_hit_ie) begin
                r_ie <= wdata;
            end
        end
    end

    // Read mux; unimplemented IF bits read back as 1.
    always_comb begin
        rdata = 8'hff;
        if (w_hit_if) begin
            rdata[NUM_SRC-1:0] = r_if;
        end else if (w_hit_ie) begin
            rdata = r_ie;
        end
    end

    assign sel = rd & (w_hit_if | w_hit_ie);

    // IE bits at or above NUM_SRC never pend.
    always_comb begin
        irq = '0;
        irq[NUM_SRC-1:0] = r_if & r_ie[NUM_SRC-1:0];
    end

    assign wake = |irq;

endmodule : sm83_irq_ctrl
`default_nettype wire

// File: tb/tb_sm83_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sm83_irq_ctrl
// Description : Directed self-checking bench for sm83_irq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sm83_irq_ctrl;

    localparam logic [15:0] C_IF_ADR = 16'hff0f;
    localparam logic [15:0] C_IE_ADR = 16'hffff;

    logic        clk;
    logic        n_reset;
    logic [4:0]  src;
    logic [15:0] adr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        rd;
    logic        wr;
    logic        sel;
    logic [7:0]  irq;
    logic [7:0]  iack;
    logic        wake;

    int n_checks = 0;
    int n_fail   = 0;

    sm83_irq_ctrl #(
        .NUM_IRQS    (8),
        .NUM_SRC     (5),
        .SYNC_STAGES (2),
        .IF_ADR      (C_IF_ADR),
        .IE_ADR      (C_IE_ADR)
    ) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .src     (src),
        .adr     (adr),
        .wdata   (wdata),
        .rdata   (rdata),
        .rd      (rd),
        .wr      (wr),
        .sel     (sel),
        .irq     (irq),
        .iack    (iack),
        .wake    (wake)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-cycle write: wr high across exactly one rising edge.
    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        adr   = a;
        wdata = d;
        wr    = 1'b1;
        @(negedge clk);
        wr    = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        adr = a;
        rd  = 1'b1;
        #1;
        d   = rdata;
        rd  = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        n_reset = 1'b0;
        src = '0; adr = '0; wdata = '0; rd = 1'b0; wr = 1'b0; iack = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (irq !== 8'h00 || wake !== 1'b0) begin
            n_fail++; $display("FAIL reset_irq: irq=%h wake=%b expected 00/0", irq, wake);
        end
        n_reset = 1'b1;
        @(negedge clk);
        bus_read(C_IF_ADR, d);
        n_checks++;
        if (d !== 8'he0) begin n_fail++; $display("FAIL reset_if: got %h expected e0", d); end
        bus_read(C_IE_ADR, d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL reset_ie: got %h expected 00", d); end
    endtask

    task automatic test_basic();
        logic [7:0] d;
        bus_write(C_IE_ADR, 8'h04);
        src[2] = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (irq !== 8'h00) begin n_fail++; $display("FAIL basic_early: irq=%h expected 00", irq); end
        @(negedge clk);
        src[2] = 1'b0;
        n_checks++;
        if (irq !== 8'h04 || wake !== 1'b1) begin
            n_fail++; $display("FAIL basic_irq: irq=%h wake=%b expected 04/1", irq, wake);
        end
        bus_read(C_IF_ADR, d);
        n_checks++;
        if (d !== 8'he4) begin n_fail++; $display("FAIL basic_if: got %h expected e4", d); end
        iack = 8'h04;
        @(negedge clk);
        iack = 8'h00;
        n_checks++;
        if (irq !== 8'h00 || wake !== 1'b0) begin
            n_fail++; $display("FAIL basic_ack: irq=%h wake=%b expected 00/0", irq, wake);
        end
        bus_read(C_IF_ADR, d);
        n_checks++;
        if (d !== 8'he0) begin n_fail++; $display("FAIL basic_if_clr: got %h expected e0", d); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_masked();
        logic [7:0] d;
        bus_write(C_IE_ADR, 8'h00);
        src[0] = 1'b1;
        repeat (3) @(negedge clk);
        src[0] = 1'b0;
        bus_read(C_IF_ADR, d);
        n_checks++;
        if (d !== 8'he1) begin n_fail++; $display("FAIL masked_if: got %h expected e1", d); end
        n_checks++;
        if (irq !== 8'h00 || wake !== 1'b0) begin
            n_fail++; $display("FAIL masked_irq: irq=%h wake=%b expected 00/0", irq, wake);
        end
        bus_write(C_IE_ADR, 8'hff);
        n_checks++;
        if (irq !== 8'h01 || wake !== 1'b1) begin
            n_fail++; $display("FAIL unmasked_irq: irq=%h wake=%b expected 01/1", irq, wake);
        end
        bus_read(C_IE_ADR, d);
        n_checks++;
        if (d !== 8'hff) begin n_fail++; $display("FAIL ie_ff: got %h expected ff", d); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_collision();
        logic [7:0] d;
        src[1] = 1'b1;
        repeat (2) @(negedge clk);
        // The edge reaches IF on the next rising edge, together with ack and write.
        iack  = 8'h02;
        adr   = C_IF_ADR;
        wdata = 8'h00;
        wr    = 1'b1;
        @(negedge clk);
        iack  = 8'h00;
        wr    = 1'b0;
        src[1] = 1'b0;
        bus_read(C_IF_ADR, d);
        n_checks++;
        if (d !== 8'he2) begin n_fail++; $display("FAIL collision_if: got %h expected e2", d); end
        n_checks++;
        if (irq !== 8'h02) begin n_fail++; $display("FAIL collision_irq: irq=%h expected 02", irq); end
        iack = 8'h02;
        @(negedge clk);
        iack = 8'h00;
        repeat (3) @(negedge clk);
        bus_read(C_IF_ADR, d);
        n_checks++;
        if (d !== 8'he0) begin n_fail++; $display("FAIL collision_clr: got %h expected e0", d); end
    endtask

    task automatic test_held_write();
        logic [7:0] d;
        adr   = C_IF_ADR;
        wdata = 8'h1f;
        wr    = 1'b1;
        repeat (2) @(negedge clk);
        iack = 8'h01;
        @(negedge clk);
        iack = 8'h00;
        @(negedge clk);
        wr = 1'b0;
        @(negedge clk);
        bus_read(C_IF_ADR, d);
        n_checks++;
        if (d !== 8'hfe) begin n_fail++; $display("FAIL held_write_if: got %h expected fe", d); end
        n_checks++;
        if (irq !== 8'h1e) begin n_fail++; $display("FAIL held_write_irq: irq=%h expected 1e", irq); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        bus_write(C_IE_ADR, 8'h1f);
        bus_write(C_IF_ADR, 8'h1f);
        n_checks++;
        if (irq !== 8'h1f) begin n_fail++; $display("FAIL pre_reset_irq: irq=%h expected 1f", irq); end
        @(posedge clk);
        #3;
        n_reset = 1'b0;
        #1;
        n_checks++;
        if (irq !== 8'h00 || wake !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_irq: irq=%h wake=%b expected 00/0", irq, wake);
        end
        bus_read(C_IF_ADR, d);
        n_checks++;
        if (d !== 8'he0) begin n_fail++; $display("FAIL async_reset_if: got %h expected e0", d); end
        bus_read(C_IE_ADR, d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL async_reset_ie: got %h expected 00", d); end
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_map_strobes();
        logic [7:0] d;
        adr = 16'hff0e;
        rd  = 1'b1;
        #1;
        n_checks++;
        if (sel !== 1'b0 || rdata !== 8'hff) begin
            n_fail++; $display("FAIL sel_miss: sel=%b rdata=%h expected 0/ff", sel, rdata);
        end
        adr = C_IE_ADR;
        #1;
        n_checks++;
        if (sel !== 1'b1) begin n_fail++; $display("FAIL sel_ie: sel=%b expected 1", sel); end
        rd = 1'b0;
        #1;
        n_checks++;
        if (sel !== 1'b0) begin n_fail++; $display("FAIL sel_no_rd: sel=%b expected 0", sel); end
        @(negedge clk);
        bus_write(C_IE_ADR, 8'h15);
        // Held write to an unmapped address, then slide onto IE while still held.
        adr   = 16'hff0e;
        wdata = 8'h00;
        wr    = 1'b1;
        repeat (3) @(negedge clk);
        adr = C_IE_ADR;
        repeat (2) @(negedge clk);
        wr = 1'b0;
        @(negedge clk);
        bus_read(C_IE_ADR, d);
        n_checks++;
        if (d !== 8'h15) begin n_fail++; $display("FAIL held_miss_ie: got %h expected 15", d); end
        bus_read(C_IF_ADR, d);
        n_checks++;
        if (d !== 8'he0) begin n_fail++; $display("FAIL held_miss_if: got %h expected e0", d); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        // Two sources rise together; IE has bit 4 set and bit 3 clear.
        src[4] = 1'b1;
        src[3] = 1'b1;
        repeat (3) @(negedge clk);
        src = '0;
        n_checks++;
        if (irq !== 8'h10) begin n_fail++; $display("FAIL b2b_irq: irq=%h expected 10", irq); end
        bus_read(C_IF_ADR, d);
        n_checks++;
        if (d !== 8'hf8) begin n_fail++; $display("FAIL b2b_if: got %h expected f8", d); end
        // Multi-bit ack clears both.
        iack = 8'h18;
        @(negedge clk);
        iack = 8'h00;
        bus_read(C_IF_ADR, d);
        n_checks++;
        if (d !== 8'he0) begin n_fail++; $display("FAIL b2b_ack: got %h expected e0", d); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_masked();
        test_collision();
        test_held_write();
        test_reset_mid();
        test_map_strobes();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sm83_irq_ctrl
`default_nettype wire
